instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute control for an 8-bit accumulator machine.
// Fetches 12-bit instructions {opcode, operand} from a program ROM, decodes
// them into datapath strobes, sequences the program counter (including
// conditional jumps on a registered compare flag), stalls on IN/OUT
// valid/ready handshakes and parks in HALT until reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rom_addr  [7:0]     program ROM address (mirrors pc)
//   rom_data  [11:0]    instruction word from ROM, same-cycle
//   alu_op    [3:0]     opcode of the held instruction
//   operand   [7:0]     operand of the held instruction
//   alu_eq              datapath compare result, used by CMPI
//   acc_we, mem_we      accumulator / data-memory write strobes
//   in_valid, in_ready  IN handshake
//   out_valid, out_ready OUT handshake (data = acc)
//   halt                high while parked in HALT
//   pc        [7:0]     program counter (debug)
module instr_sequencer #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic [3:0]  alu_op,
    output logic [7:0]  operand,
    input  logic        alu_eq,
    output logic        acc_we,
    output logic        mem_we,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        halt,
    output logic [7:0]  pc
);

    localparam int unsigned PC_W  = 8;
    localparam int unsigned IR_W  = 12;
    localparam int unsigned OP_W  = 4;

    localparam logic [OP_W-1:0] OP_LD   = 4'd0;
    localparam logic [OP_W-1:0] OP_ST   = 4'd1;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd2;
    localparam logic [OP_W-1:0] OP_SUBI = 4'd3;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd4;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd5;
    localparam logic [OP_W-1:0] OP_CMPI = 4'd6;
    localparam logic [OP_W-1:0] OP_JMP  = 4'd7;
    localparam logic [OP_W-1:0] OP_JNE  = 4'd8;
    localparam logic [OP_W-1:0] OP_JEQ  = 4'd9;
    localparam logic [OP_W-1:0] OP_OUT  = 4'd10;
    localparam logic [OP_W-1:0] OP_IN   = 4'd12;
    localparam logic [OP_W-1:0] OP_HLT  = 4'd15;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_q, pc_nxt, pc_inc;
    logic [IR_W-1:0]   ir, ir_nxt;
    logic              eq_flag, eq_nxt;
    logic [OP_W-1:0]   op;
    logic [PC_W-1:0]   opnd;

    assign op       = ir[11:8];
    assign opnd     = ir[7:0];
    assign pc_inc   = pc_q + PC_W'(1);

    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign alu_op   = op;
    assign operand  = opnd;
    assign halt     = (state == HALT);

    // State, PC, IR and compare flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            ir      <= IR_W'(0);
            eq_flag <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            ir      <= ir_nxt;
            eq_flag <= eq_nxt;
        end
    end

    // Next-state, PC sequencing and decoded strobes.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir;
        eq_nxt    = eq_flag;
        acc_we    = 1'b0;
        mem_we    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state)
            FETCH: begin
                ir_nxt    = rom_data;
                state_nxt = EXEC;
            end

            EXEC: begin
                state_nxt = FETCH;
                pc_nxt    = pc_inc;
                case (op)
                    OP_LD, OP_ADDI, OP_SUBI, OP_MUL, OP_ADD: acc_we = 1'b1;
                    OP_ST:   mem_we = 1'b1;
                    OP_CMPI: eq_nxt = alu_eq;
                    OP_JMP:  pc_nxt = opnd;
                    OP_JNE:  if (!eq_flag) pc_nxt = opnd;
                    OP_JEQ:  if (eq_flag)  pc_nxt = opnd;
                    OP_OUT: begin
                        out_valid = 1'b1;
                        // Hold in EXEC with pc frozen until the consumer accepts.
                        if (!out_ready) begin
                            state_nxt = EXEC;
                            pc_nxt    = pc_q;
                        end
                    end
                    OP_IN: begin
                        in_ready = 1'b1;
                        // Accumulator is written only on the handshake cycle.
                        if (in_valid) begin
                            acc_we = 1'b1;
                        end else begin
                            state_nxt = EXEC;
                            pc_nxt    = pc_q;
                        end
                    end
                    OP_HLT: begin
                        state_nxt = HALT;
                        pc_nxt    = pc_q;
                    end
                    default: ;  // NOP and reserved opcodes
                endcase
            end

            HALT: ;  // parked until reset

            default: state_nxt = FETCH;
        endcase
    end

endmodule
